// File: rtl/uart_coord_framer_if.sv
// Coordinate output bundle from the UART framer to the servo predictor.
// The framer drives it; the predictor/PWM side only listens.
interface uart_coord_framer_if;
   logic [7:0] coord_x;
   logic [7:0] coord_y;
   logic       coord_valid;

   modport master (
      output coord_x,
      output coord_y,
      output coord_valid
   );

   modport slave (
      input coord_x,
      input coord_y,
      input coord_valid
   );
endinterface

// File: rtl/uart_coord_framer.sv
// UART receiver plus SYNC/X/Y/SUM packet framer.
// Emits validated coordinates, an error counter and a link-alive flag.
module uart_coord_framer #(
   parameter int         CLK_FREQ     = 50000000,
   parameter int         BAUD_RATE    = 9600,
   parameter logic [7:0] SYNC_BYTE    = 8'hAA,
   parameter int         BYTE_TIMEOUT = 20,
   parameter int         LINK_TIMEOUT = 5000000
) (
   input  logic                   clk50mhz,
   input  logic                   rst,
   input  logic                   uart_rx,
   uart_coord_framer_if.master    coord,
   output logic [7:0]             err_count,
   output logic                   link_ok
);

   localparam int BAUD_TICK = CLK_FREQ / BAUD_RATE;
   localparam logic [31:0] TICK_M1 = 32'(BAUD_TICK - 1);
   localparam logic [31:0] HALF    = 32'(BAUD_TICK / 2);
   localparam logic [31:0] GAP_LIM = 32'(BYTE_TIMEOUT * BAUD_TICK);
   localparam logic [31:0] LINK_LD = 32'(LINK_TIMEOUT);

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT
   } rx_state_t;

   typedef enum logic [1:0] {
      P_HUNT, P_GET_X, P_GET_Y, P_GET_SUM
   } pk_state_t;

   rx_state_t   rx_st;
   pk_state_t   pk_st;
   logic        rx_meta;
   logic        rx_sync;
   logic [31:0] baud_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shift_q;
   logic        byte_valid;
   logic        frame_err;
   logic [7:0]  x_q;
   logic [7:0]  y_q;
   logic [31:0] gap_cnt;
   logic [31:0] link_cnt;
   logic [7:0]  sum_calc;
   logic        timeout;
   logic        sum_ok;
   logic        sum_bad;
   logic        err_ev;

   always_ff @(posedge clk50mhz) begin
      if (rst) begin
         rx_meta    <= 1'b1;
         rx_sync    <= 1'b1;
         rx_st      <= RX_IDLE;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         shift_q    <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_meta    <= uart_rx;
         rx_sync    <= rx_meta;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         unique case (rx_st)
            RX_IDLE: begin
               if (!rx_sync) begin
                  rx_st    <= RX_START;
                  baud_cnt <= HALF;
               end
            end
            RX_START: begin
               if (baud_cnt != 0) begin
                  baud_cnt <= baud_cnt - 1;
               end else if (!rx_sync) begin
                  rx_st    <= RX_DATA;
                  baud_cnt <= TICK_M1;
                  bit_idx  <= '0;
               end else begin
                  rx_st <= RX_IDLE;
               end
            end
            RX_DATA: begin
               if (baud_cnt != 0) begin
                  baud_cnt <= baud_cnt - 1;
               end else begin
                  shift_q  <= {rx_sync, shift_q[7:1]};
                  bit_idx  <= bit_idx + 3'd1;
                  baud_cnt <= TICK_M1;
                  if (bit_idx == 3'd7) rx_st <= RX_STOP;
               end
            end
            RX_STOP: begin
               if (baud_cnt != 0) begin
                  baud_cnt <= baud_cnt - 1;
               end else if (rx_sync) begin
                  byte_valid <= 1'b1;
                  rx_st      <= RX_IDLE;
               end else begin
                  frame_err <= 1'b1;
                  rx_st     <= RX_WAIT;
               end
            end
            RX_WAIT: begin
               if (rx_sync) rx_st <= RX_IDLE;
            end
            default: rx_st <= RX_IDLE;
         endcase
      end
   end

   // shift_q is stable while byte_valid is high, so it doubles as the byte
   assign sum_calc = SYNC_BYTE + x_q + y_q;
   assign timeout  = (pk_st != P_HUNT) && (gap_cnt >= GAP_LIM);
   assign sum_ok   = byte_valid && !timeout && (pk_st == P_GET_SUM)
                     && (shift_q == sum_calc);
   assign sum_bad  = byte_valid && !timeout && (pk_st == P_GET_SUM)
                     && (shift_q != sum_calc);
   assign err_ev   = frame_err | timeout | sum_bad;

   always_ff @(posedge clk50mhz) begin
      if (rst) begin
         pk_st             <= P_HUNT;
         x_q               <= '0;
         y_q               <= '0;
         gap_cnt           <= '0;
         coord.coord_x     <= 8'd128;
         coord.coord_y     <= 8'd128;
         coord.coord_valid <= 1'b0;
         err_count         <= '0;
         link_cnt          <= '0;
         link_ok           <= 1'b0;
      end else begin
         coord.coord_valid <= 1'b0;
         if (err_ev && err_count != 8'hFF) err_count <= err_count + 8'd1;
         if (byte_valid || pk_st == P_HUNT) gap_cnt <= '0;
         else gap_cnt <= gap_cnt + 1;
         if (frame_err || timeout) begin
            pk_st   <= P_HUNT;
            gap_cnt <= '0;
         end else if (byte_valid) begin
            unique case (pk_st)
               P_HUNT: begin
                  if (shift_q == SYNC_BYTE) pk_st <= P_GET_X;
               end
               P_GET_X: begin
                  x_q   <= shift_q;
                  pk_st <= P_GET_Y;
               end
               P_GET_Y: begin
                  y_q   <= shift_q;
                  pk_st <= P_GET_SUM;
               end
               P_GET_SUM: begin
                  pk_st <= P_HUNT;
                  if (sum_ok) begin
                     coord.coord_x     <= x_q;
                     coord.coord_y     <= y_q;
                     coord.coord_valid <= 1'b1;
                  end
               end
            endcase
         end
         if (sum_ok) begin
            link_cnt <= LINK_LD;
            link_ok  <= 1'b1;
         end else if (link_cnt != 0) begin
            link_cnt <= link_cnt - 1;
            link_ok  <= (link_cnt != 32'd1);
         end else begin
            link_ok <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_coord_framer.sv
// Bench for uart_coord_framer: directed packet cases, random packets
// against a packet-level model, link timeout and error saturation.
module tb_uart_coord_framer;

   localparam int BT    = 8;
   localparam int LINKT = 4000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] err_count;
   logic       link_ok;

   uart_coord_framer_if cif ();

   uart_coord_framer #(
      .CLK_FREQ     (80000),
      .BAUD_RATE    (10000),
      .SYNC_BYTE    (8'hAA),
      .BYTE_TIMEOUT (20),
      .LINK_TIMEOUT (LINKT)
   ) dut (
      .clk50mhz  (clk),
      .rst       (rst),
      .uart_rx   (rx),
      .coord     (cif),
      .err_count (err_count),
      .link_ok   (link_ok)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int pulses  = 0;
   int exp_pulses = 0;
   int exp_x   = 128;
   int exp_y   = 128;
   int exp_err = 0;
   string scen = "reset";

   always @(negedge clk) if (cif.coord_valid === 1'b1) pulses++;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s/%s got=%0h exp=%0h", scen, tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
      @(negedge clk);
      rx = 1'b0;
      repeat (BT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BT) @(negedge clk);
      end
      rx = stop;
      repeat (BT) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic idle_bits(input int n);
      rx = 1'b1;
      repeat (n * BT) @(negedge clk);
   endtask

   task automatic model_err();
      if (exp_err < 255) exp_err++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_x   = 128;
      exp_y   = 128;
      exp_err = 0;
   endtask

   task automatic good_pkt(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] s;
      s = 8'((170 + int'(x) + int'(y)) % 256);
      send_byte(8'hAA);
      send_byte(x);
      send_byte(y);
      send_byte(s);
      exp_x = x;
      exp_y = y;
      exp_pulses++;
   endtask

   task automatic check_state(input bit want_link);
      idle_bits(2);
      chk("pulses", pulses, exp_pulses);
      chk("coord_x", int'(cif.coord_x), exp_x);
      chk("coord_y", int'(cif.coord_y), exp_y);
      chk("err", int'(err_count), exp_err);
      if (want_link) chk("link", int'(link_ok), 1);
   endtask

   function automatic logic [7:0] not_sync();
      logic [7:0] b;
      b = 8'($urandom);
      if (b == 8'hAA) b = 8'h55;
      return b;
   endfunction

   initial begin
      logic [7:0] x, y, s;
      int kind;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_x", int'(cif.coord_x), 128);
      chk("rst_y", int'(cif.coord_y), 128);
      chk("rst_valid", int'(cif.coord_valid), 0);
      chk("rst_err", int'(err_count), 0);
      chk("rst_link", int'(link_ok), 0);

      scen = "t1_good";
      good_pkt(8'h10, 8'h20);
      check_state(1);

      scen = "t2_badsum";
      do_reset();
      send_byte(8'hAA); send_byte(8'h10);
      send_byte(8'h20); send_byte(8'hDB);
      model_err();
      check_state(0);

      scen = "t3_junk";
      do_reset();
      send_byte(8'h55); send_byte(8'h13);
      good_pkt(8'h40, 8'h50);
      check_state(1);

      scen = "t4_syncdata";
      good_pkt(8'hAA, 8'hAA);
      check_state(1);

      scen = "t5_timeout";
      do_reset();
      send_byte(8'hAA); send_byte(8'h10);
      idle_bits(25);
      send_byte(8'h20); send_byte(8'hDA);
      model_err();
      check_state(0);
      good_pkt(8'h01, 8'h02);
      check_state(1);

      scen = "t6_frame";
      send_byte(8'hAA);
      send_byte(8'h33, 1'b0);
      idle_bits(2);
      model_err();
      check_state(0);
      good_pkt(8'h5A, 8'hC3);
      check_state(1);

      scen = "t6_rst_mid";
      send_byte(8'hAA); send_byte(8'h10);
      do_reset();
      @(negedge clk);
      chk("rst_x", int'(cif.coord_x), 128);
      chk("rst_y", int'(cif.coord_y), 128);
      chk("rst_err", int'(err_count), 0);
      chk("rst_link", int'(link_ok), 0);
      send_byte(8'h20); send_byte(8'hDA);
      check_state(0);

      scen = "t6_link";
      good_pkt(8'h77, 8'h88);
      check_state(1);
      repeat (LINKT - 100) @(negedge clk);
      chk("link_hold", int'(link_ok), 1);
      repeat (110) @(negedge clk);
      chk("link_drop", int'(link_ok), 0);

      for (int n = 0; n < 24; n++) begin
         kind = $urandom_range(0, 4);
         x = 8'($urandom);
         y = 8'($urandom);
         scen = $sformatf("rnd%0d_k%0d", n, kind);
         unique case (kind)
            0: good_pkt(x, y);
            1: begin
               s = 8'((170 + int'(x) + int'(y) + $urandom_range(1, 255)) % 256);
               send_byte(8'hAA); send_byte(x); send_byte(y); send_byte(s);
               model_err();
            end
            2: begin
               repeat ($urandom_range(1, 3)) send_byte(not_sync());
               good_pkt(x, y);
            end
            3: begin
               send_byte(8'hAA); send_byte(x);
               idle_bits(25);
               send_byte(not_sync()); send_byte(not_sync());
               model_err();
            end
            default: begin
               send_byte(8'hAA);
               if ($urandom_range(0, 1) == 1) send_byte(x);
               send_byte(y, 1'b0);
               idle_bits(1);
               model_err();
            end
         endcase
         check_state(kind == 0 || kind == 2);
      end

      scen = "saturate";
      for (int n = 0; n < 260; n++) begin
         send_byte(8'h00, 1'b0);
         idle_bits(1);
         model_err();
      end
      check_state(0);
      chk("err_sat", int'(err_count), 255);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
